// File: rtl/uivtd_if.sv
// Video timing detector bus: sampled vs/hs/de stream in, frame geometry and status out.
interface uivtd_if #(
   parameter int unsigned CNT_W = 12
);
   logic             vtd_vs_i;
   logic             vtd_hs_i;
   logic             vtd_de_i;
   logic [CNT_W-1:0] vtd_htot_o;
   logic [CNT_W-1:0] vtd_hact_o;
   logic [CNT_W-1:0] vtd_hsw_o;
   logic [CNT_W-1:0] vtd_vtot_o;
   logic [CNT_W-1:0] vtd_vact_o;
   logic [CNT_W-1:0] vtd_vsw_o;
   logic             vtd_valid_o;
   logic             vtd_lock_o;
   logic             vtd_match_o;
   logic             vtd_err_o;

   // Video source side: drives the timing stream, observes the measurements.
   modport master (
      output vtd_vs_i, vtd_hs_i, vtd_de_i,
      input  vtd_htot_o, vtd_hact_o, vtd_hsw_o,
      input  vtd_vtot_o, vtd_vact_o, vtd_vsw_o,
      input  vtd_valid_o, vtd_lock_o, vtd_match_o, vtd_err_o
   );

   // Detector side.
   modport slave (
      input  vtd_vs_i, vtd_hs_i, vtd_de_i,
      output vtd_htot_o, vtd_hact_o, vtd_hsw_o,
      output vtd_vtot_o, vtd_vact_o, vtd_vsw_o,
      output vtd_valid_o, vtd_lock_o, vtd_match_o, vtd_err_o
   );
endinterface

// File: rtl/uivtd.sv
// Video timing detector: measures line/frame geometry of a vs/hs/de stream,
// publishes it once per frame and flags lock, format match and errors.
module uivtd #(
   parameter int unsigned CNT_W        = 12,
   parameter int unsigned EXP_H_ACTIVE = 1920,
   parameter int unsigned EXP_H_TOTAL  = 2200,
   parameter int unsigned EXP_H_SYNC   = 44,
   parameter int unsigned EXP_V_ACTIVE = 1080,
   parameter int unsigned EXP_V_TOTAL  = 1125,
   parameter int unsigned EXP_V_SYNC   = 5,
   parameter int unsigned TIMEOUT      = 8388608
) (
   input  logic   vtd_clk_i,
   input  logic   vtd_rst_i,
   uivtd_if.slave vtd
);

   localparam int unsigned      SET_W    = 6 * CNT_W;
   localparam int unsigned      TMO_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
   localparam logic [TMO_W-1:0] TMO_FULL = TMO_W'(TIMEOUT);
   localparam logic [SET_W-1:0] EXP_SET  = {CNT_W'(EXP_H_TOTAL),  CNT_W'(EXP_H_ACTIVE),
                                            CNT_W'(EXP_H_SYNC),   CNT_W'(EXP_V_TOTAL),
                                            CNT_W'(EXP_V_ACTIVE), CNT_W'(EXP_V_SYNC)};

   typedef enum logic [0:0] {ST_IDLE, ST_MEAS} state_t;

   state_t           state_q, state_d;
   logic             publish_c;

   logic             vs_s1, vs_s2, hs_s1, hs_s2, de_s1, de_s2;
   logic             vs_rise, hs_rise, hs_fall, de_rise, de_fall;

   logic [CNT_W-1:0] hcnt, hswc, dec;
   logic [CNT_W-1:0] line_tot, line_act, line_sw;
   logic             hs_seen;
   logic [CNT_W-1:0] lcnt, vact_cnt, vsw_cnt;
   logic             frm_err;
   logic             sat_now, err_new;

   logic [TMO_W-1:0] tmo_cnt;
   logic             tmo_hit;

   logic [SET_W-1:0] meas_new, prev_set;
   logic             prev_valid;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

   assign vs_rise  = vs_s1 & ~vs_s2;
   assign hs_rise  = hs_s1 & ~hs_s2;
   assign hs_fall  = ~hs_s1 & hs_s2;
   assign de_rise  = de_s1 & ~de_s2;
   assign de_fall  = ~de_s1 & de_s2;

   assign sat_now  = (hcnt == CNT_MAX) | (hswc == CNT_MAX) | (dec == CNT_MAX) |
                     (lcnt == CNT_MAX) | (vact_cnt == CNT_MAX) | (vsw_cnt == CNT_MAX);
   assign err_new  = frm_err | sat_now;
   assign meas_new = {line_tot, line_act, line_sw, lcnt, vact_cnt, vsw_cnt};
   assign tmo_hit  = ~vs_rise & (tmo_cnt == TMO_LAST);

   // Two-stage input register; edges are taken between the stages.
   always_ff @(posedge vtd_clk_i) begin
      if (vtd_rst_i) begin
         vs_s1 <= 1'b0; vs_s2 <= 1'b0;
         hs_s1 <= 1'b0; hs_s2 <= 1'b0;
         de_s1 <= 1'b0; de_s2 <= 1'b0;
      end else begin
         vs_s1 <= vtd.vtd_vs_i; vs_s2 <= vs_s1;
         hs_s1 <= vtd.vtd_hs_i; hs_s2 <= hs_s1;
         de_s1 <= vtd.vtd_de_i; de_s2 <= de_s1;
      end
   end

   // Per-line measurement: line length, hsync width, active width.
   always_ff @(posedge vtd_clk_i) begin
      if (vtd_rst_i) begin
         hcnt     <= '0;
         hs_seen  <= 1'b0;
         line_tot <= '0;
         hswc     <= '0;
         line_sw  <= '0;
         dec      <= '0;
         line_act <= '0;
      end else begin
         if (hs_rise) begin
            hcnt    <= CNT_W'(1);
            hs_seen <= 1'b1;
            if (hs_seen) line_tot <= hcnt;
         end else begin
            hcnt <= sat_inc(hcnt);
         end

         if (hs_fall) begin
            line_sw <= hswc;
            hswc    <= '0;
         end else if (hs_s1) begin
            hswc <= sat_inc(hswc);
         end

         if (de_fall) begin
            line_act <= dec;
            dec      <= '0;
         end else if (de_s1) begin
            dec <= sat_inc(dec);
         end
      end
   end

   // Per-frame counters; an hs/de rise coinciding with vs rise opens the new frame.
   always_ff @(posedge vtd_clk_i) begin
      if (vtd_rst_i) begin
         lcnt     <= '0;
         vact_cnt <= '0;
         vsw_cnt  <= '0;
         frm_err  <= 1'b0;
      end else if (vs_rise) begin
         lcnt     <= CNT_W'(hs_rise);
         vact_cnt <= CNT_W'(de_rise);
         vsw_cnt  <= CNT_W'(hs_rise);
         frm_err  <= 1'b0;
      end else begin
         if (hs_rise)          lcnt     <= sat_inc(lcnt);
         if (de_rise)          vact_cnt <= sat_inc(vact_cnt);
         if (hs_rise && vs_s1) vsw_cnt  <= sat_inc(vsw_cnt);
         if (sat_now)          frm_err  <= 1'b1;
      end
   end

   // Loss-of-signal timer, restarted by every vs rise and parked once expired.
   always_ff @(posedge vtd_clk_i) begin
      if (vtd_rst_i) begin
         tmo_cnt <= '0;
      end else if (vs_rise) begin
         tmo_cnt <= '0;
      end else if (tmo_cnt != TMO_FULL) begin
         tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
   end

   // Frame tracking state register.
   always_ff @(posedge vtd_clk_i) begin
      if (vtd_rst_i) state_q <= ST_IDLE;
      else           state_q <= state_d;
   end

   // IDLE discards the partial frame up to the first vs rise; timeout falls back to IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (vs_rise) state_d = ST_MEAS;
         ST_MEAS: if (tmo_hit) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Publish strobe for a vs rise that closes a fully measured frame.
   always_comb begin
      publish_c = 1'b0;
      if (state_q == ST_MEAS && vs_rise) publish_c = 1'b1;
   end

   // Registered outputs, status flags and previous-set history.
   always_ff @(posedge vtd_clk_i) begin
      if (vtd_rst_i) begin
         vtd.vtd_htot_o  <= '0;
         vtd.vtd_hact_o  <= '0;
         vtd.vtd_hsw_o   <= '0;
         vtd.vtd_vtot_o  <= '0;
         vtd.vtd_vact_o  <= '0;
         vtd.vtd_vsw_o   <= '0;
         vtd.vtd_valid_o <= 1'b0;
         vtd.vtd_lock_o  <= 1'b0;
         vtd.vtd_match_o <= 1'b0;
         vtd.vtd_err_o   <= 1'b0;
         prev_set        <= '0;
         prev_valid      <= 1'b0;
      end else begin
         vtd.vtd_valid_o <= publish_c;
         if (publish_c) begin
            vtd.vtd_htot_o  <= line_tot;
            vtd.vtd_hact_o  <= line_act;
            vtd.vtd_hsw_o   <= line_sw;
            vtd.vtd_vtot_o  <= lcnt;
            vtd.vtd_vact_o  <= vact_cnt;
            vtd.vtd_vsw_o   <= vsw_cnt;
            vtd.vtd_lock_o  <= prev_valid & (meas_new == prev_set) & ~err_new;
            vtd.vtd_match_o <= (meas_new == EXP_SET) & ~err_new;
            vtd.vtd_err_o   <= err_new;
            prev_set        <= meas_new;
            prev_valid      <= 1'b1;
         end else if (tmo_hit) begin
            vtd.vtd_lock_o  <= 1'b0;
            vtd.vtd_match_o <= 1'b0;
            vtd.vtd_err_o   <= 1'b1;
            prev_valid      <= 1'b0;
         end
      end
   end

endmodule

// File: doc/uivtd.md
# uivtd

Video timing detector. Samples a vs/hs/de stream, such as one produced by the team's video timing generator or an external video source, and measures the horizontal and vertical frame geometry of every frame. It publishes the measurements once per frame, reports whether consecutive frames are stable (lock), and reports whether the geometry matches a configured expected format. It sits at the input of the video pipeline, in front of the frame buffer writer, as a format monitor.

## Interface
Parameters:
- CNT_W, 12, width of every measurement counter and output.
- EXP_H_ACTIVE, 1920, expected active pixels per line.
- EXP_H_TOTAL, 2200, expected clocks per line.
- EXP_H_SYNC, 44, expected hsync width in clocks.
- EXP_V_ACTIVE, 1080, expected active lines per frame.
- EXP_V_TOTAL, 1125, expected lines per frame.
- EXP_V_SYNC, 5, expected vsync width in lines.
- TIMEOUT, 2^23, clocks without a vs rising edge before loss of signal is declared.

Ports:
- vtd_clk_i  in  1  pixel clock; all logic on its rising edge.
- vtd_rst_i  in  1  synchronous, active-high reset.
- vtd_vs_i  in  1  vsync, active high, synchronous to vtd_clk_i.
- vtd_hs_i  in  1  hsync, active high.
- vtd_de_i  in  1  data enable, active high.
- vtd_htot_o, vtd_hact_o, vtd_hsw_o  out  CNT_W  measured line total, active width, hsync width (clocks).
- vtd_vtot_o, vtd_vact_o, vtd_vsw_o  out  CNT_W  measured frame total, active lines, vsync width (lines).
- vtd_valid_o  out  1  one-cycle pulse when a new measurement set is published.
- vtd_lock_o  out  1  last two published sets identical and error-free.
- vtd_match_o  out  1  last published set equals the EXP_* parameters and is error-free.
- vtd_err_o  out  1  last published set had a counter saturation, or the timeout has fired.

## Operation
- Input stage: vs/hs/de are registered once (s1), then again (s2). Rising edge = s1 & ~s2. Falling edge = ~s1 & s2. All edge logic below runs on the s1/s2 pair.
- Line counters:
  - hcnt loads 1 on an hs rise and increments otherwise.
  - On each hs rise after the first since reset, hcnt is captured as line_tot.
  - hswc counts clocks with hs high and is captured as line_sw on an hs fall.
  - dec counts clocks with de high and is captured as line_act on a de fall.
  - hswc and dec clear when captured.
- Frame counters:
  - lcnt counts hs rises.
  - vact_c counts de rises (one per active line).
  - vsw_c counts hs rises while vs (s1) is high.
- Saturation: every counter saturates at 2^CNT_W-1. Reaching saturation sets the frame error flag.
- Frame boundary on a vs rise:
  - First vs rise after reset: counters clear and nothing is published. The partial frame is discarded.
  - Every later vs rise:
    - Publish line_tot, line_act and line_sw (the last values captured in the frame) and lcnt, vact_c and vsw_c to the outputs.
    - Pulse vtd_valid_o.
    - Update lock, match and err.
    - Clear the frame counters and the error flag.
  - An hs rise in the same cycle as the vs rise is counted into the new frame.
- Lock rule: vtd_lock_o = (new set == previous published set) and no error. The previous set is held in internal registers. The first publish after reset always gives lock 0.
- Timeout: a clock counter clears on each vs rise. When it reaches TIMEOUT:
  - vtd_lock_o and vtd_match_o go to 0 and vtd_err_o goes to 1.
  - Measurement outputs hold their values and no valid pulse is issued.
  - The next vs rise is treated as the first vs rise after reset (discarded).
- Reset mid-operation:
  - All outputs, counters and history are cleared.
  - Measurement restarts as after power-up.

## Timing
- Reset values:
  - all measurement outputs 0
  - vtd_valid_o 0
  - vtd_lock_o 0
  - vtd_match_o 0
  - vtd_err_o 0
- Latency: vtd_vs_i is first sampled high at clock edge t. s1 rises at t, the edge is detected during cycle t..t+1, and the outputs, vtd_valid_o, lock, match and err all update at edge t+1.
  - Observed from the vs_i change, this is 2 clocks.
- vtd_valid_o is high for exactly one cycle per published frame. No back-pressure.
- lock, match and err change only with vtd_valid_o or on timeout/reset.
- Measured values are pure integer counts. Totals include the sync and blanking clocks. For example, a line of 2200 clocks reads 2200, not 2199.

## Test plan
- 1080p60 stream with the default geometry (2200/1920/44, 1125/1080/5):
  - no valid pulse on the first vs rise
  - first valid pulse on the second vs rise, with outputs 2200, 1920, 44, 1125, 1080, 5 and match=1, lock=0, err=0
  - third frame gives lock=1
- Small format (htot 20, hact 12, hsw 3, vtot 10, vact 6, vsw 2) for 4 frames: outputs 20/12/3/10/6/2 and match=0; lock=1 from the second published frame on.
- Change hact from 12 to 14 in the 5th frame: that frame's publish gives hact=14 and lock=0; the next identical frame gives lock=1.
- Line length 5000 clocks with CNT_W=12: htot=4095, err=1, lock=0, match=0.
- Stop vs for TIMEOUT clocks (TIMEOUT overridden to 1000):
  - err=1, lock=0, no valid pulse
  - the first vs rise after resume is discarded
  - the second vs rise publishes and clears err
- Assert vtd_rst_i for one cycle mid-frame while locked: all outputs 0 on the next cycle; re-lock after 3 vs rises.
